// File: rtl/imu_burst_reader.sv
// imu_burst_reader
//   Periodically reads a contiguous block of IMU data registers through an i2c
//   byte master. Little-endian byte pairs are assembled into signed 16-bit
//   words, sign-extended to OUT_W and published all together with a one-cycle
//   data_valid strobe. Aborted bursts (NACK, short transfer, timeout) leave
//   data_out untouched and bump a saturating error counter.
// Ports
//   sys_clk, resetn            clock (posedge) and async active-low reset
//   enable                     poll timer run control
//   cmd_valid/cmd_ready        read request handshake to the i2c master
//   cmd_dev/cmd_reg/cmd_len    device address, start register, byte count
//   rx_valid/rx_data           received byte stream
//   xfer_done/xfer_nack        transfer completion / failure pulses
//   data_out/data_valid        published channels (k at [k*OUT_W +: OUT_W])
//   busy                       high whenever a burst is in progress
//   err_count                  saturating count of aborted bursts
module imu_burst_reader #(
  parameter int         N_CHAN      = 9,
  parameter int         OUT_W       = 36,
  parameter logic [6:0] DEV_ADDR    = 7'h28,
  parameter logic [7:0] START_REG   = 8'h08,
  parameter int         POLL_CYCLES = 50000,
  parameter int         TIMEOUT     = 4096
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  input  logic                    enable,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [6:0]              cmd_dev,
  output logic [7:0]              cmd_reg,
  output logic [7:0]              cmd_len,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    xfer_done,
  input  logic                    xfer_nack,
  output logic [N_CHAN*OUT_W-1:0] data_out,
  output logic                    data_valid,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam int NB     = 2 * N_CHAN;
  localparam int IDX_W  = $clog2(NB + 1);
  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]  NB_L      = IDX_W'(NB);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_PUB   = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  state_t                    state_r, state_s;
  logic [POLL_W-1:0]         poll_cnt_r;
  logic                      poll_tick_s;
  logic [TO_W-1:0]           to_cnt_r;
  logic [IDX_W-1:0]          idx_r, idx_inc_s;
  logic                      capture_s;
  logic [7:0]                shadow_r [NB];
  logic [7:0]                shadow_s [NB];
  logic [N_CHAN*OUT_W-1:0]   data_out_r, data_pub_s;
  logic                      data_valid_r, data_valid_s;
  logic                      cmd_valid_r, cmd_valid_s;
  logic                      busy_r, busy_s;
  logic [7:0]                err_count_r, err_count_s;

  // Sign-extend a 16-bit two's complement word to OUT_W bits.
  function automatic logic [OUT_W-1:0] sext16(input logic [15:0] w);
    logic signed [15:0]      w_s;
    logic signed [OUT_W-1:0] r_s;
    w_s = signed'(w);
    r_s = w_s;
    return r_s;
  endfunction

  assign cmd_dev    = DEV_ADDR;
  assign cmd_reg    = START_REG;
  assign cmd_len    = 8'(NB);
  assign cmd_valid  = cmd_valid_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;
  assign err_count  = err_count_r;

  // Poll timer: runs whenever enabled (also during bursts), held at zero when disabled.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      poll_cnt_r <= '0;
    end else if (!enable || poll_cnt_r == POLL_LAST) begin
      poll_cnt_r <= '0;
    end else begin
      poll_cnt_r <= poll_cnt_r + POLL_W'(1);
    end
  end

  // Ticks that land while a burst is running are simply not acted on.
  assign poll_tick_s = enable && (poll_cnt_r == POLL_LAST);

  // Byte capture: the index saturates at NB so surplus bytes are dropped.
  always_comb begin
    capture_s = (state_r == ST_RECV) && rx_valid && (idx_r < NB_L);
    if (capture_s) begin
      idx_inc_s = idx_r + IDX_W'(1);
    end else begin
      idx_inc_s = idx_r;
    end
    for (int i = 0; i < NB; i++) begin
      if (capture_s && idx_r == IDX_W'(i)) begin
        shadow_s[i] = rx_data;
      end else begin
        shadow_s[i] = shadow_r[i];
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; completion is judged against the index including this cycle's byte.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (poll_tick_s) state_s = ST_REQ;
        else             state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (cmd_ready)               state_s = ST_RECV;
        else if (to_cnt_r == TO_LAST) state_s = ST_ABORT;
        else                         state_s = ST_REQ;
      end
      ST_RECV: begin
        if (xfer_nack)                           state_s = ST_ABORT;
        else if (xfer_done)                      state_s = (idx_inc_s == NB_L) ? ST_PUB : ST_ABORT;
        else if (!rx_valid && to_cnt_r == TO_LAST) state_s = ST_ABORT;
        else                                     state_s = ST_RECV;
      end
      ST_PUB:   state_s = ST_IDLE;
      ST_ABORT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output decode of the next state, so registered outputs line up with the state they describe.
  always_comb begin
    cmd_valid_s  = (state_s == ST_REQ);
    busy_s       = (state_s != ST_IDLE);
    data_valid_s = (state_s == ST_PUB);
    if (state_s == ST_ABORT && err_count_r != 8'hFF) begin
      err_count_s = err_count_r + 8'd1;
    end else begin
      err_count_s = err_count_r;
    end
    for (int k = 0; k < N_CHAN; k++) begin
      data_pub_s[k*OUT_W +: OUT_W] = sext16({shadow_s[2*k+1], shadow_s[2*k]});
    end
  end

  // Registered outputs; data_out is loaded only on a complete burst.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      cmd_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      data_valid_r <= 1'b0;
      err_count_r  <= 8'd0;
      data_out_r   <= '0;
    end else begin
      cmd_valid_r  <= cmd_valid_s;
      busy_r       <= busy_s;
      data_valid_r <= data_valid_s;
      err_count_r  <= err_count_s;
      if (state_s == ST_PUB) begin
        data_out_r <= data_pub_s;
      end
    end
  end

  // Per-event timeout counter, cleared on state change, cmd accept and every received byte.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt_r <= '0;
    end else if (state_s != state_r) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_RECV && rx_valid) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_REQ || state_r == ST_RECV) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  // Byte index and shadow buffer.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      idx_r <= '0;
      for (int i = 0; i < NB; i++) shadow_r[i] <= 8'h00;
    end else begin
      if (state_r == ST_REQ && state_s == ST_RECV) begin
        idx_r <= '0;
      end else if (state_r == ST_RECV) begin
        idx_r <= idx_inc_s;
      end
      for (int i = 0; i < NB; i++) shadow_r[i] <= shadow_s[i];
    end
  end

endmodule

// File: tb/tb_imu_burst_reader.sv
// Directed testbench for imu_burst_reader (N_CHAN=9, OUT_W=36, POLL_CYCLES=100, TIMEOUT=64).
module tb_imu_burst_reader;

  localparam int N_CHAN = 9;
  localparam int OUT_W  = 36;
  localparam int POLL   = 100;
  localparam int TOUT   = 64;

  logic sys_clk = 1'b0;
  logic resetn = 1'b0, enable = 1'b0, cmd_ready = 1'b0;
  logic rx_valid = 1'b0, xfer_done = 1'b0, xfer_nack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic cmd_valid, data_valid, busy;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_len, err_count;
  logic [N_CHAN*OUT_W-1:0] data_out;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] bytes [0:31];
  logic [N_CHAN*OUT_W-1:0] last_pub = '0;

  imu_burst_reader #(
    .N_CHAN(N_CHAN), .OUT_W(OUT_W), .DEV_ADDR(7'h28), .START_REG(8'h08),
    .POLL_CYCLES(POLL), .TIMEOUT(TOUT)
  ) dut (
    .sys_clk(sys_clk), .resetn(resetn), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len), .rx_valid(rx_valid), .rx_data(rx_data),
    .xfer_done(xfer_done), .xfer_nack(xfer_nack), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .err_count(err_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_cmd(input string tag);
    int k;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_cmd: cmd_valid=%b, required 1 within 300 cycles", tag, cmd_valid);
    end
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic stream(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      rx_valid  = 1'b1;
      rx_data   = bytes[i];
      xfer_done = done_last && (i == n - 1);
      tick();
    end
    rx_valid  = 1'b0;
    xfer_done = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({cmd_valid, data_valid, busy} !== 3'b000 || err_count !== 8'd0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: cv=%b dv=%b busy=%b err=%0d data=%h, required all 0",
               cmd_valid, data_valid, busy, err_count, data_out);
    end
  endtask

  task automatic test_publish();
    logic [N_CHAN*OUT_W-1:0] exp;
    for (int i = 0; i < 18; i++) bytes[i] = 8'h00;
    bytes[0] = 8'h00; bytes[1] = 8'h80; bytes[2] = 8'hFF;
    bytes[3] = 8'h7F; bytes[4] = 8'h34; bytes[5] = 8'h12;
    exp = '0;
    exp[0*OUT_W +: OUT_W] = 36'hF_FFFF_8000;
    exp[1*OUT_W +: OUT_W] = 36'h0_0000_7FFF;
    exp[2*OUT_W +: OUT_W] = 36'h0_0000_1234;
    wait_cmd("publish");
    n_checks++;
    if (cmd_dev !== 7'h28 || cmd_reg !== 8'h08 || cmd_len !== 8'd18) begin
      n_fail++;
      $display("FAIL cmd_fields: dev=%h reg=%h len=%0d, required 28 08 18", cmd_dev, cmd_reg, cmd_len);
    end
    accept();
    stream(18, 1'b1);
    n_checks++;
    if (data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL publish_valid: data_valid=%b, required 1", data_valid);
    end
    for (int k = 0; k < N_CHAN; k++) begin
      n_checks++;
      if (data_out[k*OUT_W +: OUT_W] !== exp[k*OUT_W +: OUT_W]) begin
        n_fail++;
        $display("FAIL publish_ch%0d: got %h, required %h", k, data_out[k*OUT_W +: OUT_W], exp[k*OUT_W +: OUT_W]);
      end
    end
    tick();
    n_checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL publish_pulse: data_valid=%b busy=%b, required 0 0", data_valid, busy);
    end
    last_pub = exp;
  endtask

  task automatic test_nack();
    logic [7:0] e0;
    e0 = err_count;
    for (int i = 0; i < 5; i++) bytes[i] = 8'hA0 + 8'(i);
    wait_cmd("nack");
    accept();
    stream(5, 1'b0);
    xfer_nack = 1'b1;
    tick();
    xfer_nack = 1'b0;
    n_checks++;
    if (err_count !== e0 + 8'd1 || data_valid !== 1'b0 || data_out !== last_pub) begin
      n_fail++;
      $display("FAIL nack_abort: err=%0d dv=%b data=%h, required err=%0d dv=0 data=%h",
               err_count, data_valid, data_out, e0 + 8'd1, last_pub);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nack_idle: busy=%b dv=%b, required 0 0", busy, data_valid);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] e0;
    int cnt;
    e0 = err_count;
    cnt = 0;
    wait_cmd("timeout");
    while (cmd_valid === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != TOUT) begin
      n_fail++;
      $display("FAIL timeout_len: cmd_valid held %0d cycles, required %0d", cnt, TOUT);
    end
    n_checks++;
    if (err_count !== e0 + 8'd1 || cmd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_abort: err=%0d cv=%b busy=%b, required err=%0d cv=0 busy=1",
               err_count, cmd_valid, busy, e0 + 8'd1);
    end
    tick();
  endtask

  task automatic test_length();
    logic [7:0] e0;
    logic [OUT_W-1:0] e;
    e0 = err_count;
    for (int i = 0; i < 20; i++) bytes[i] = 8'h10 + 8'(i);
    bytes[17] = 8'hC3;
    bytes[18] = 8'hFF;
    bytes[19] = 8'h80;
    wait_cmd("short");
    accept();
    stream(17, 1'b1);
    n_checks++;
    if (err_count !== e0 + 8'd1 || data_valid !== 1'b0 || data_out !== last_pub) begin
      n_fail++;
      $display("FAIL short_abort: err=%0d dv=%b, required err=%0d dv=0 data unchanged",
               err_count, data_valid, e0 + 8'd1);
    end
    tick();
    wait_cmd("long");
    accept();
    stream(20, 1'b1);
    n_checks++;
    if (data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL long_valid: data_valid=%b, required 1", data_valid);
    end
    for (int k = 0; k < N_CHAN; k++) begin
      e = {{(OUT_W-16){bytes[2*k+1][7]}}, bytes[2*k+1], bytes[2*k]};
      n_checks++;
      if (data_out[k*OUT_W +: OUT_W] !== e) begin
        n_fail++;
        $display("FAIL long_ch%0d: got %h, required %h", k, data_out[k*OUT_W +: OUT_W], e);
      end
      last_pub[k*OUT_W +: OUT_W] = e;
    end
    n_checks++;
    if (data_out[8*OUT_W +: OUT_W] !== 36'hF_FFFF_C320) begin
      n_fail++;
      $display("FAIL long_ch8_const: got %h, required FFFFFC320", data_out[8*OUT_W +: OUT_W]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) bytes[i] = 8'h55;
    wait_cmd("reset_mid");
    accept();
    stream(3, 1'b0);
    resetn = 1'b0;
    #2;
    n_checks++;
    if ({cmd_valid, data_valid, busy} !== 3'b000 || err_count !== 8'd0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: cv=%b dv=%b busy=%b err=%0d data=%h, required all 0",
               cmd_valid, data_valid, busy, err_count, data_out);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b cv=%b, required 0 0", busy, cmd_valid);
    end
  endtask

  task automatic test_poll();
    int t [0:3];
    int nseen;
    int quiet;
    nseen = 0;
    quiet = 0;
    cmd_ready = 1'b1;
    for (int c = 0; c < 350; c++) begin
      tick();
      if (cmd_valid === 1'b1 && nseen < 4) begin
        t[nseen] = c;
        nseen++;
      end
    end
    n_checks++;
    if (nseen < 3) begin
      n_fail++;
      $display("FAIL poll_count: saw %0d requests, required at least 3", nseen);
    end else begin
      n_checks++;
      if (t[1] - t[0] != POLL || t[2] - t[1] != POLL) begin
        n_fail++;
        $display("FAIL poll_period: intervals %0d %0d, required %0d", t[1] - t[0], t[2] - t[1], POLL);
      end
    end
    enable = 1'b0;
    repeat (80) tick();
    for (int c = 0; c < 250; c++) begin
      tick();
      if (cmd_valid === 1'b1) quiet++;
    end
    n_checks++;
    if (quiet != 0) begin
      n_fail++;
      $display("FAIL poll_disabled: %0d request cycles, required 0", quiet);
    end
    cmd_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    resetn = 1'b1;
    enable = 1'b1;
    test_publish();
    test_nack();
    test_timeout();
    test_length();
    test_reset_mid();
    test_poll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
